// File: rtl/bg_object_spawner_pkg.sv
// Shared constants and helpers for the background object spawner.
// Holds coordinate-width and spawn-value rules also used by the obstacle spawner.
package bg_object_spawner_pkg;

  localparam int SCREEN_W_BITS = 10;
  localparam int GEN_LINE_DEF  = 250;
  localparam int SPAWN_LO_W    = 5;

  function automatic int pos_w(input int conv);
    return SCREEN_W_BITS - conv;
  endfunction

  // Spawn values are all-ones above a 5-bit random offset.
  function automatic int spawn_hi_ones(input int pw);
    return pw - SPAWN_LO_W;
  endfunction

endpackage

// File: rtl/bg_obj_slot.sv
// One scrolling object slot: position register with saturating
// subtract on motion and a load port for spawns.
module bg_obj_slot #(
  parameter int POS_W  = 10,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              move,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [POS_W-1:0]  load_val,
  output logic [POS_W-1:0]  pos,
  output logic              active
);

  logic [POS_W-1:0] step_ext;
  logic [POS_W-1:0] pos_nxt;

  assign step_ext = POS_W'(step);

  always_comb begin
    pos_nxt = pos;
    if (load) begin
      pos_nxt = load_val;
    end else if (move && (pos != '0)) begin
      pos_nxt = (step_ext >= pos) ? '0 : pos - step_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      active <= 1'b0;
    end else if (!freeze) begin
      pos    <= pos_nxt;
      active <= (pos_nxt != '0);
    end
  end

endmodule

// File: rtl/bg_object_spawner.sv
// Round-robin background scenery spawner; a new object is released
// only after the previous one has scrolled past the generation line.
module bg_object_spawner
  import bg_object_spawner_pkg::*;
#(
  parameter int N_OBJ    = 2,
  parameter int CONV     = 0,
  parameter int GEN_LINE = GEN_LINE_DEF,
  parameter int STEP_W   = 3,
  localparam int POS_W   = pos_w(CONV),
  localparam int IDX_W   = $clog2(N_OBJ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   move_tick,
  input  logic [STEP_W-1:0]      step,
  input  logic [7:0]             rng,
  output logic [N_OBJ*POS_W-1:0] obj_pos,
  output logic [N_OBJ-1:0]       obj_active,
  output logic                   spawn_pulse,
  output logic [IDX_W-1:0]       spawn_idx
);

  localparam int HI_W = spawn_hi_ones(POS_W);
  localparam logic [POS_W-1:0] GEN_P = POS_W'(GEN_LINE);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_OBJ - 1);

  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] last_idx;
  logic             gate_open;

  logic [POS_W-1:0] pos_arr [N_OBJ];
  logic [N_OBJ-1:0] load_vec;
  logic [POS_W-1:0] last_pos;
  logic [POS_W-1:0] spawn_val;
  logic             spawn;
  logic             unused_rng;

  assign unused_rng = ^{rng[7], rng[1:0]};
  assign spawn_val  = {{HI_W{1'b1}}, rng[6:2]};
  assign last_pos   = pos_arr[last_idx];
  assign spawn      = gate_open && (pos_arr[next_idx] == '0) && !freeze;

  for (genvar k = 0; k < N_OBJ; k++) begin : g_slot
    assign load_vec[k] = spawn && (next_idx == IDX_W'(k));

    bg_obj_slot #(
      .POS_W  (POS_W),
      .STEP_W (STEP_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .freeze   (freeze),
      .move     (move_tick),
      .step     (step),
      .load     (load_vec[k]),
      .load_val (spawn_val),
      .pos      (pos_arr[k]),
      .active   (obj_active[k])
    );

    assign obj_pos[k*POS_W +: POS_W] = pos_arr[k];
  end

  // An idle last slot reads 0, which also satisfies the <= test.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_idx    <= '0;
      last_idx    <= LAST_SLOT;
      gate_open   <= 1'b1;
      spawn_pulse <= 1'b0;
      spawn_idx   <= '0;
    end else if (freeze) begin
      spawn_pulse <= 1'b0;
    end else if (spawn) begin
      last_idx    <= next_idx;
      next_idx    <= (next_idx == LAST_SLOT) ? '0 : next_idx + 1'b1;
      gate_open   <= 1'b0;
      spawn_pulse <= 1'b1;
      spawn_idx   <= next_idx;
    end else begin
      spawn_pulse <= 1'b0;
      if (last_pos <= GEN_P) begin
        gate_open <= 1'b1;
      end
    end
  end

endmodule
